// File: rtl/sysid_pkg.sv
// Shared types and constants for the sysid check master.
// Holds the FSM state enum, register offsets and data width.
package sysid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID_REQ,
      ST_ID_WAIT,
      ST_TS_REQ,
      ST_TS_WAIT,
      ST_FIN
   } state_t;

   localparam int SYSID_DATA_W    = 32;
   localparam int SYSID_ID_OFFSET = 0;
   localparam int SYSID_TS_OFFSET = 4;

endpackage

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that reads the sysid ID and timestamp words
// and compares them with expected values.
// Ports: clock/reset (sync, active high); start pulse;
//   avm_* read master; busy/done/pass; id_ok/ts_ok/timeout;
//   id_value/ts_value (last captured words).
module sysid_check_master
   import sysid_pkg::*;
#(
   parameter int                      ADDR_W         = 32,
   parameter logic [ADDR_W-1:0]       BASE_ADDR      = '0,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = '0,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'd1374756872,
   parameter int                      TIMEOUT_CYCLES = 1024,
   parameter bit                      AUTO_START     = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   output logic [ADDR_W-1:0]       avm_address,
   output logic                    avm_read,
   input  logic                    avm_waitrequest,
   input  logic [SYSID_DATA_W-1:0] avm_readdata,
   input  logic                    avm_readdatavalid,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    id_ok,
   output logic                    ts_ok,
   output logic                    timeout,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] ts_value
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ID_ADDR =
      BASE_ADDR + ADDR_W'(SYSID_ID_OFFSET);
   localparam logic [ADDR_W-1:0] TS_ADDR =
      BASE_ADDR + ADDR_W'(SYSID_TS_OFFSET);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             auto_pend;

   logic accept;
   logic in_req;
   logic in_wait;
   logic cap;
   logic expire;

   assign accept  = avm_read & ~avm_waitrequest;
   assign in_req  = (state == ST_ID_REQ) |
                    (state == ST_TS_REQ);
   assign in_wait = (state == ST_ID_WAIT) |
                    (state == ST_TS_WAIT);
   assign cap     = in_wait & avm_readdatavalid;
   // A capture on the last allowed cycle beats the timeout.
   assign expire  = (in_req | in_wait) &
                    (cnt == CNT_LAST) & ~cap;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         auto_pend   <= AUTO_START;
         avm_read    <= 1'b0;
         avm_address <= BASE_ADDR;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start || auto_pend) begin
                  auto_pend   <= 1'b0;
                  state       <= ST_ID_REQ;
                  cnt         <= '0;
                  avm_read    <= 1'b1;
                  avm_address <= ID_ADDR;
                  busy        <= 1'b1;
                  pass        <= 1'b0;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout     <= 1'b0;
               end
            end
            ST_ID_REQ, ST_TS_REQ: begin
               cnt <= cnt + 1'b1;
               if (expire) begin
                  state    <= ST_FIN;
                  avm_read <= 1'b0;
                  timeout  <= 1'b1;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  pass     <= 1'b0;
               end else if (accept) begin
                  avm_read <= 1'b0;
                  state    <= (state == ST_ID_REQ) ?
                              ST_ID_WAIT : ST_TS_WAIT;
               end
            end
            ST_ID_WAIT: begin
               cnt <= cnt + 1'b1;
               if (cap) begin
                  id_value    <= avm_readdata;
                  id_ok       <= (avm_readdata == EXPECTED_ID);
                  state       <= ST_TS_REQ;
                  cnt         <= '0;
                  avm_read    <= 1'b1;
                  avm_address <= TS_ADDR;
               end else if (expire) begin
                  state   <= ST_FIN;
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  pass    <= 1'b0;
               end
            end
            ST_TS_WAIT: begin
               cnt <= cnt + 1'b1;
               if (cap) begin
                  ts_value <= avm_readdata;
                  ts_ok    <= (avm_readdata == EXPECTED_TS);
                  // pass is presented in FIN together with done.
                  pass     <= id_ok &
                              (avm_readdata == EXPECTED_TS);
                  state    <= ST_FIN;
                  done     <= 1'b1;
                  busy     <= 1'b0;
               end else if (expire) begin
                  state   <= ST_FIN;
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  pass    <= 1'b0;
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state    <= ST_IDLE;
               avm_read <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
